mc_history_buffer: RTL and testbench

- Parametrised multi-channel history buffer. Keeps the last DEPTH accepted samples for each of NUM_CH channels (I/Q for complex paths) and presents them as one flat bus to the adaptive-filter update and Kalman stages.
- Adds the following on top of a plain output shift register: valid/ready handshake, fill tracking, a primed indication, freeze/snapshot hold, synchronous clear, and a saturating drop counter.

---
 rtl/mc_history_buffer.sv | 117 +++++++++++
 tb/tb_mc_history_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_history_buffer.sv
// Multi-channel history buffer.
// Holds the last DEPTH accepted samples (all channels together) and presents
// them as one flat bus, slot 0 = newest. Adds a valid/ready input handshake,
// fill tracking, a primed pulse, freeze (snapshot hold), synchronous clear
// and a saturating count of samples refused while frozen.
module mc_history_buffer #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 8,
    parameter  int NUM_CH = 2,
    parameter  int DROP_W = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CH*DATA_W-1:0]        in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            clear,
    input  logic                            freeze,
    output logic [DEPTH*NUM_CH*DATA_W-1:0]  hist_bus,
    output logic [CNT_W-1:0]                fill_cnt,
    output logic                            full,
    output logic                            hist_valid,
    output logic [DROP_W-1:0]               drop_cnt
);

    // One sample = all channels of one time step, kept together so channels
    // can never cross-mix.
    localparam int SW = NUM_CH * DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_PRIMED  = 2'd2
    } state_t;

    // Packed so slot m lands at bits [m*SW +: SW] of the flattened bus.
    logic [DEPTH-1:0][SW-1:0] slot_q;
    logic [CNT_W-1:0]         fill_q;
    logic [CNT_W-1:0]         fill_d;
    logic                     full_q;
    logic                     hv_q;
    logic                     hv_d;
    logic [DROP_W-1:0]        drop_q;
    logic [DROP_W-1:0]        drop_d;
    state_t                   state_q;
    logic                     accept;
    logic                     refuse;

    // Ready depends only on freeze so an upstream source sees it even in reset.
    assign in_ready = !freeze;
    assign accept   = in_valid && in_ready;
    // A sample offered in the same cycle as clear is discarded, not dropped.
    assign refuse   = in_valid && freeze && !clear;

    // Next-state values for the counters and the window-ready pulse.
    always_comb begin
        fill_d = fill_q;
        if (accept && (fill_q != DEPTH_CNT)) begin
            fill_d = fill_q + 1'b1;
        end
        hv_d   = accept && (fill_d == DEPTH_CNT);
        drop_d = drop_q;
        if (refuse && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Sample shift register: newest sample enters slot 0, oldest falls off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (clear) begin
            slot_q <= '0;
        end else if (accept) begin
            slot_q <= {slot_q[DEPTH-2:0], in_data};
        end
    end

    // Fill-state machine with its registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            fill_q  <= '0;
            full_q  <= 1'b0;
            hv_q    <= 1'b0;
            drop_q  <= '0;
        end else if (clear) begin
            state_q <= ST_EMPTY;
            fill_q  <= '0;
            full_q  <= 1'b0;
            hv_q    <= 1'b0;
            drop_q  <= '0;
        end else begin
            fill_q  <= fill_d;
            full_q  <= (fill_d == DEPTH_CNT);
            hv_q    <= hv_d;
            drop_q  <= drop_d;
            if (accept) begin
                case (state_q)
                    ST_EMPTY:   state_q <= (fill_d == DEPTH_CNT) ? ST_PRIMED : ST_FILLING;
                    ST_FILLING: state_q <= (fill_d == DEPTH_CNT) ? ST_PRIMED : ST_FILLING;
                    ST_PRIMED:  state_q <= ST_PRIMED;
                    default:    state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    assign hist_bus   = slot_q;
    assign fill_cnt   = fill_q;
    assign full       = full_q;
    assign hist_valid = hv_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_mc_history_buffer.sv
// Testbench for mc_history_buffer: directed walk through the main scenarios,
// then randomized traffic, all compared against a queue-based reference model.
module tb_mc_history_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int NUM_CH = 2;
    localparam int DROP_W = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SW     = NUM_CH * DATA_W;
    localparam int BW     = DEPTH * SW;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk;
    logic              rst_n;
    logic [SW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic              clear;
    logic              freeze;
    logic [BW-1:0]     hist_bus;
    logic [CNT_W-1:0]  fill_cnt;
    logic              full;
    logic              hist_valid;
    logic [DROP_W-1:0] drop_cnt;

    mc_history_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .NUM_CH(NUM_CH),
        .DROP_W(DROP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .freeze    (freeze),
        .hist_bus  (hist_bus),
        .fill_cnt  (fill_cnt),
        .full      (full),
        .hist_valid(hist_valid),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: newest-first list of retained samples, plus counters.
    logic [SW-1:0] model_q[$];
    int            model_drops = 0;
    bit            model_hv    = 1'b0;

    task automatic check_eq(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] model_bus();
        logic [BW-1:0] b;
        b = '0;
        for (int m = 0; m < model_q.size(); m++) begin
            b[m*SW +: SW] = model_q[m];
        end
        return b;
    endfunction

    function automatic logic [SW-1:0] iq(input int i_val, input int q_val);
        logic [DATA_W-1:0] i_w;
        logic [DATA_W-1:0] q_w;
        i_w = DATA_W'(i_val);
        q_w = DATA_W'(q_val);
        return {q_w, i_w};
    endfunction

    task automatic model_reset();
        model_q.delete();
        model_drops = 0;
        model_hv    = 1'b0;
    endtask

    task automatic compare_all(input string ctx);
        check_eq({ctx, ":hist_bus"},   hist_bus,   model_bus());
        check_eq({ctx, ":fill_cnt"},   fill_cnt,   model_q.size());
        check_eq({ctx, ":full"},       full,       model_q.size() == DEPTH);
        check_eq({ctx, ":hist_valid"}, hist_valid, model_hv);
        check_eq({ctx, ":drop_cnt"},   drop_cnt,   model_drops);
    endtask

    // One clock cycle: drive at the falling edge, update the model with the
    // rules of the buffer, then compare at the next falling edge.
    task automatic cycle(input logic v, input logic [SW-1:0] d, input logic f,
                         input logic c, input string ctx);
        in_valid = v;
        in_data  = d;
        freeze   = f;
        clear    = c;
        #1;
        check_eq({ctx, ":in_ready"}, in_ready, !f);
        model_hv = 1'b0;
        if (c) begin
            model_reset();
        end else if (f) begin
            if (v && model_drops < DROP_MAX) model_drops++;
        end else if (v) begin
            model_q.push_front(d);
            if (model_q.size() > DEPTH) void'(model_q.pop_back());
            model_hv = (model_q.size() == DEPTH);
        end
        @(negedge clk);
        compare_all(ctx);
        $display("cycle %s v=%0b f=%0b c=%0b d=%h fill=%0d hv=%0b drop=%0d",
                 ctx, v, f, c, d, fill_cnt, hist_valid, drop_cnt);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        freeze   = 1'b0;
        clear    = 1'b0;
        model_reset();

        // 1. Reset values
        #12;
        check_eq("rst:in_ready", in_ready, 1'b1);
        compare_all("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 2. Eight accepts, I=k, Q=-k
        for (int k = 1; k <= DEPTH; k++) begin
            cycle(1'b1, iq(k, -k), 1'b0, 1'b0, $sformatf("fill%0d", k));
            check_eq("fill_seq", fill_cnt, k);
            check_eq("hv_seq", hist_valid, k == DEPTH);
        end
        check_eq("t2:slot0", hist_bus[0 +: SW], iq(8, -8));
        check_eq("t2:slot7", hist_bus[7*SW +: SW], iq(1, -1));
        check_eq("t2:full", full, 1'b1);

        // 3. Ninth accept keeps the window full and pulses again
        cycle(1'b1, iq(9, -9), 1'b0, 1'b0, "ninth");
        check_eq("t3:slot0", hist_bus[0 +: SW], iq(9, -9));
        check_eq("t3:slot7", hist_bus[7*SW +: SW], iq(2, -2));
        check_eq("t3:fill", fill_cnt, DEPTH);
        check_eq("t3:hv", hist_valid, 1'b1);

        // 4. Frozen offers are refused and counted, saturating
        for (int k = 0; k < 3; k++) cycle(1'b1, iq(16'h7FFF, 16'h7FFF), 1'b1, 1'b0, "frz");
        check_eq("t4:drop3", drop_cnt, 3);
        check_eq("t4:slot0", hist_bus[0 +: SW], iq(9, -9));
        for (int k = 0; k < 300; k++) cycle(1'b1, iq(16'h7FFF, 16'h7FFF), 1'b1, 1'b0, "frzsat");
        check_eq("t4:drop_sat", drop_cnt, DROP_MAX);

        // 5. Clear beats a simultaneous sample, then one accept
        cycle(1'b1, SW'(5), 1'b0, 1'b1, "clr");
        check_eq("t5:bus", hist_bus, '0);
        check_eq("t5:drop", drop_cnt, 0);
        cycle(1'b1, SW'(6), 1'b0, 1'b0, "after_clr");
        check_eq("t5:slot0", hist_bus[0 +: SW], SW'(6));
        check_eq("t5:fill", fill_cnt, 1);

        // 6. Asynchronous reset in the middle of a cycle
        for (int k = 0; k < 3; k++) cycle(1'b1, iq(20 + k, -20 - k), 1'b0, 1'b0, "pre_rst");
        cycle(1'b1, iq(1, 1), 1'b1, 1'b0, "pre_rst_drop");
        in_valid = 1'b0;
        freeze   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check_eq("async_rst:in_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, iq(33, -33), 1'b0, 1'b0, "post_rst");
        check_eq("t6:fill", fill_cnt, 1);
        check_eq("t6:hv", hist_valid, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic v;
            logic f;
            logic c;
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 60) == 0);
            cycle(v, SW'($urandom), f, c, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
